// File: rtl/sm_display_pkg.sv
// Shared types and helpers for the sign-magnitude BCD display: FSM states,
// segment constants, the 7-segment lookup and the magnitude-width rule.
package sm_display_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Active-low gfedcba; anything outside 0-9 shows blank.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic int mag_width(input int size, input string sgn);
    return (sgn == "Yes") ? size - 1 : size;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment decoder for the scan-selected digit.
module seg7_decode
  import sm_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);
  assign segments = seg7(nibble);
endmodule

// File: rtl/sm_bcd_display.sv
// Counter-value consumer: sequential shift-add-3 binary-to-BCD conversion with
// a start/busy/valid handshake, driving a multiplexed active-low 7-seg display.
module sm_bcd_display
  import sm_display_pkg::*;
#(
  parameter int    Size    = 5,
  parameter string Signed  = "Yes",
  parameter int    Digits  = 2,
  parameter int    ScanDiv = 1000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [Size-1:0]       Data,
  input  logic                  Load,
  output logic                  Busy,
  output logic                  Valid,
  output logic                  Sign,
  output logic [4*Digits-1:0]   Bcd,
  output logic [6:0]            Segments,
  output logic [Digits:0]       Anodes
);

  localparam int     MagW     = mag_width(Size, Signed);
  localparam bit     IsSigned = (Signed == "Yes");
  localparam int     BW       = 4 * Digits;
  localparam int     CW       = (MagW > 1) ? $clog2(MagW) : 1;
  localparam int     AW       = Digits + 1;
  localparam int     IW       = $clog2(Digits + 1);
  localparam int     PW       = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
  localparam longint MaxMag   = (longint'(1) << MagW) - 1;
  localparam longint Pow10    = longint'(10) ** Digits;

  if (Pow10 <= MaxMag) begin : g_digits_check
    $error("Digits too small for the magnitude range");
  end
  if (ScanDiv < 1) begin : g_scan_check
    $error("ScanDiv must be at least 1");
  end

  // ---------------- converter ----------------
  state_e          state;
  logic [BW-1:0]   work_bcd, adj;
  logic [MagW-1:0] work_mag;
  logic            work_sign;
  logic [CW-1:0]   bit_cnt;

  always_comb begin
    adj = work_bcd;
    for (int i = 0; i < Digits; i++)
      if (work_bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= IDLE;
      Busy      <= 1'b0;
      Valid     <= 1'b0;
      Sign      <= 1'b0;
      Bcd       <= '0;
      work_bcd  <= '0;
      work_mag  <= '0;
      work_sign <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      Valid <= 1'b0;
      case (state)
        IDLE: if (Load) begin
          work_mag  <= Data[MagW-1:0];
          work_bcd  <= '0;
          // negative zero collapses to plain zero
          work_sign <= IsSigned && Data[Size-1] && (Data[MagW-1:0] != '0);
          bit_cnt   <= CW'(MagW - 1);
          Busy      <= 1'b1;
          state     <= SHIFT;
        end
        SHIFT: begin
          {work_bcd, work_mag} <= {adj, work_mag} << 1;
          bit_cnt              <= bit_cnt - 1'b1;
          if (bit_cnt == '0) state <= DONE;
        end
        DONE: begin
          Bcd   <= work_bcd;
          Sign  <= work_sign;
          Valid <= 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- display scanner ----------------
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [3:0]    nib;
  logic          hi_zero;
  logic [6:0]    seg_dec, seg_next;

  always_comb begin
    nib     = '0;
    hi_zero = 1'b1;
    for (int i = 0; i < Digits; i++) begin
      if (IW'(i) == idx) nib = Bcd[4*i +: 4];
      if (IW'(i) >= idx && Bcd[4*i +: 4] != 4'd0) hi_zero = 1'b0;
    end
    if (idx == IW'(Digits))            seg_next = Sign ? SEG_MINUS : SEG_BLANK;
    else if (idx != '0 && hi_zero)     seg_next = SEG_BLANK;
    else                               seg_next = seg_dec;
  end

  seg7_decode u_dec (.nibble(nib), .segments(seg_dec));

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pre      <= '0;
      idx      <= '0;
      Segments <= SEG_BLANK;
      Anodes   <= '1;
    end else begin
      if (pre == PW'(ScanDiv - 1)) begin
        pre <= '0;
        idx <= (idx == IW'(Digits)) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      Anodes   <= ~(AW'(1) << idx);
      Segments <= seg_next;
    end
  end

endmodule

// File: tb/tb_sm_bcd_display.sv
// Self-checking bench: table vectors, hand sequences and random conversions
// against an arithmetic model, for a signed and an unsigned instance.
module tb_sm_bcd_display;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [4:0] data_s, data_u;
  logic       load_s, load_u;
  logic       busy_s, valid_s, sign_s, busy_u, valid_u, sign_u;
  logic [7:0] bcd_s, bcd_u;
  logic [6:0] seg_s, seg_u;
  logic [2:0] an_s, an_u;

  sm_bcd_display #(.Size(5), .Signed("Yes"), .Digits(2), .ScanDiv(4)) dut_s (
    .Clock(clock), .Reset(reset), .Data(data_s), .Load(load_s), .Busy(busy_s),
    .Valid(valid_s), .Sign(sign_s), .Bcd(bcd_s), .Segments(seg_s), .Anodes(an_s));

  sm_bcd_display #(.Size(5), .Signed("No"), .Digits(2), .ScanDiv(4)) dut_u (
    .Clock(clock), .Reset(reset), .Data(data_u), .Load(load_u), .Busy(busy_u),
    .Valid(valid_u), .Sign(sign_u), .Bcd(bcd_u), .Segments(seg_u), .Anodes(an_u));

  bit         sel_u;
  logic       m_busy, m_valid, m_sign;
  logic [7:0] m_bcd;
  logic [6:0] m_seg;
  logic [2:0] m_an;
  always_comb begin
    m_busy  = sel_u ? busy_u  : busy_s;
    m_valid = sel_u ? valid_u : valid_s;
    m_sign  = sel_u ? sign_u  : sign_s;
    m_bcd   = sel_u ? bcd_u   : bcd_s;
    m_seg   = sel_u ? seg_u   : seg_s;
    m_an    = sel_u ? an_u    : an_s;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: plain decimal arithmetic
  logic [6:0] segtab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [7:0] ref_bcd(input logic [4:0] d, input bit uns);
    int m;
    m = uns ? int'(d) : int'(d[3:0]);
    return {4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic ref_sign(input logic [4:0] d, input bit uns);
    return !uns && d[4] && (d[3:0] != 4'd0);
  endfunction

  function automatic logic [6:0] exp_seg(input int pos, input logic [7:0] b, input logic s);
    if (pos == 2) return s ? 7'h3F : 7'h7F;
    if (pos == 1) return (b[7:4] == 4'd0) ? 7'h7F : segtab[b[7:4]];
    return segtab[b[3:0]];
  endfunction

  task automatic convert(input logic [4:0] d);
    int magw, busy_n, valid_n, valid_at;
    magw = sel_u ? 5 : 4; busy_n = 0; valid_n = 0; valid_at = -1;
    @(negedge clock);
    if (sel_u) begin data_u = d; load_u = 1'b1; end
    else       begin data_s = d; load_s = 1'b1; end
    @(posedge clock);
    @(negedge clock);
    load_s = 1'b0; load_u = 1'b0;
    if (m_busy) busy_n++;
    for (int n = 1; n <= magw + 3; n++) begin
      @(negedge clock);
      if (m_busy) busy_n++;
      if (m_valid) begin valid_n++; valid_at = n; end
    end
    chk("busy_cycles", busy_n, magw + 1);
    chk("valid_pulses", valid_n, 1);
    chk("valid_latency", valid_at, magw + 1);
    chk("bcd_model", m_bcd, ref_bcd(d, sel_u));
    chk("sign_model", m_sign, ref_sign(d, sel_u));
  endtask

  task automatic check_display(input int cycles, input logic [7:0] b, input logic s);
    logic [2:0] prev;
    int run, pos;
    bit seen_change;
    prev = 3'b111; run = 0; seen_change = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      case (m_an)
        3'b110:  pos = 0;
        3'b101:  pos = 1;
        3'b011:  pos = 2;
        default: pos = -1;
      endcase
      chk("anode_onehot", pos >= 0, 1);
      if (pos >= 0) chk("segments", m_seg, exp_seg(pos, b, s));
      if (c > 0 && m_an != prev) begin
        chk("anode_order", m_an, {prev[1:0], prev[2]});
        if (seen_change) chk("anode_hold", run, 4);
        seen_change = 1; run = 1;
      end else run++;
      prev = m_an;
    end
  endtask

  typedef struct {
    logic [4:0] d;
    bit         uns;
    logic [7:0] bcd;
    logic       sign;
  } vec_t;

  vec_t vecs [9];
  int   vcnt, first_v, second_v;
  logic [4:0] rd;

  initial begin
    vecs[0] = '{5'b01101, 1'b0, 8'h13, 1'b0};
    vecs[1] = '{5'b11111, 1'b0, 8'h15, 1'b1};
    vecs[2] = '{5'b10000, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{5'b00111, 1'b0, 8'h07, 1'b0};
    vecs[4] = '{5'b11001, 1'b0, 8'h09, 1'b1};
    vecs[5] = '{5'b01010, 1'b0, 8'h10, 1'b0};
    vecs[6] = '{5'd31,    1'b1, 8'h31, 1'b0};
    vecs[7] = '{5'd0,     1'b1, 8'h00, 1'b0};
    vecs[8] = '{5'd16,    1'b1, 8'h16, 1'b0};

    reset = 1'b0; load_s = 1'b0; load_u = 1'b0; data_s = '0; data_u = '0; sel_u = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", {busy_s, busy_u}, 2'b00);
    chk("rst_valid", {valid_s, valid_u}, 2'b00);
    chk("rst_sign", {sign_s, sign_u}, 2'b00);
    chk("rst_bcd", {bcd_s, bcd_u}, 16'h0000);
    chk("rst_segments", {seg_s, seg_u}, 14'h3FFF);
    chk("rst_anodes", {an_s, an_u}, 6'b111111);
    reset = 1'b1;

    foreach (vecs[i]) begin
      sel_u = vecs[i].uns;
      convert(vecs[i].d);
      chk("bcd_table", m_bcd, vecs[i].bcd);
      chk("sign_table", m_sign, vecs[i].sign);
      check_display(12, vecs[i].bcd, vecs[i].sign);
    end

    // Load while busy is ignored and Data changes have no effect
    sel_u = 0;
    @(negedge clock); data_s = 5'd3; load_s = 1'b1;
    @(posedge clock);
    @(negedge clock); load_s = 1'b0;
    @(posedge clock);
    @(negedge clock); data_s = 5'd9; load_s = 1'b1;
    @(posedge clock);
    @(negedge clock); load_s = 1'b0;
    vcnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clock);
      if (valid_s) vcnt++;
    end
    chk("busy_load_pulses", vcnt, 1);
    chk("busy_load_bcd", bcd_s, 8'h03);

    // Reset mid-conversion aborts with no published result
    @(negedge clock); data_s = 5'd9; load_s = 1'b1;
    @(posedge clock);
    @(negedge clock); load_s = 1'b0;
    @(posedge clock);
    @(negedge clock); reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("abort_busy", busy_s, 1'b0);
    chk("abort_valid", valid_s, 1'b0);
    chk("abort_bcd", bcd_s, 8'h00);
    chk("abort_anodes", an_s, 3'b111);
    reset = 1'b1;
    vcnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      if (valid_s) vcnt++;
    end
    chk("abort_no_valid", vcnt, 0);
    chk("abort_bcd_hold", bcd_s, 8'h00);

    // Level Load: one conversion per MagW+2 cycles
    @(negedge clock); data_s = 5'd5; load_s = 1'b1;
    first_v = -1; second_v = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (valid_s) begin
        if (first_v < 0) first_v = n;
        else if (second_v < 0) second_v = n;
      end
    end
    load_s = 1'b0;
    chk("b2b_spacing", second_v - first_v, 6);
    chk("b2b_bcd", bcd_s, 8'h05);
    repeat (8) @(negedge clock);

    // Random conversions against the arithmetic model
    for (int r = 0; r < 24; r++) begin
      sel_u = ($urandom_range(0, 1) == 1);
      rd = 5'($urandom);
      convert(rd);
      if (r % 4 == 0) check_display(12, ref_bcd(rd, sel_u), ref_sign(rd, sel_u));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
